board_ram_arbiter: RTL and testbench

Shares the single-port on-chip board/move RAM between the HPS Avalon-MM slave port of the chess control block and NUM_ENG internal search engines (move generator, evaluator). It issues at most one RAM access per cycle and stalls the HPS with waitrequest. Engines are served round-robin. A fixed-latency tag pipeline routes read data back to the originating requester.

---
 rtl/board_ram_arbiter.sv | 133 +++++++++++++
 tb/tb_board_ram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ram_arbiter.sv
// Single-port board/move RAM arbiter: HPS Avalon-MM slave vs NUM_ENG round-robin engines.
// Optional HPS fairness guard is built only when ARB_FAIR_EN is defined.
module board_ram_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 15,
  parameter int unsigned NUM_ENG       = 2,
  parameter int unsigned MAX_SLAVE_RUN = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          slave_address,
  input  logic                           slave_read,
  input  logic                           slave_write,
  input  logic [DATA_WIDTH-1:0]          slave_writedata,
  input  logic [DATA_WIDTH/8-1:0]        slave_byteenable,
  output logic                           slave_waitrequest,
  output logic [DATA_WIDTH-1:0]          slave_readdata,
  output logic                           slave_readdatavalid,
  input  logic [NUM_ENG-1:0]             eng_req,
  input  logic [NUM_ENG-1:0]             eng_we,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0]  eng_addr,
  input  logic [NUM_ENG*DATA_WIDTH-1:0]  eng_wdata,
  output logic [NUM_ENG-1:0]             eng_gnt,
  output logic [NUM_ENG-1:0]             eng_rvalid,
  output logic [DATA_WIDTH-1:0]          eng_rdata,
  output logic [ADDR_WIDTH-1:0]          ram_address,
  output logic                           ram_wren,
  output logic [DATA_WIDTH/8-1:0]        ram_byteenable,
  output logic [DATA_WIDTH-1:0]          ram_writedata,
  input  logic [DATA_WIDTH-1:0]          ram_readdata
);

  localparam int unsigned IDX_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  typedef struct packed {
    logic             valid;
    logic             is_slave;
    logic [IDX_W-1:0] idx;
  } tag_t;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] rr_sel;
  logic             rr_found;
  tag_t             tag0_q, tag1_q, tag0_d;
  logic             slave_req, any_eng, force_eng, slave_gnt, eng_gnt_any;

  assign slave_req = slave_read | slave_write;
  assign any_eng   = |eng_req;

`ifdef ARB_FAIR_EN
  localparam int unsigned CNT_W = $clog2(MAX_SLAVE_RUN + 1);
  logic [CNT_W-1:0] run_q, run_d;

  assign force_eng = any_eng & (run_q == CNT_W'(MAX_SLAVE_RUN));

  always_comb begin
    run_d = run_q;
    if (eng_gnt_any || !any_eng) run_d = '0;
    else if (slave_gnt)          run_d = run_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) run_q <= '0;
    else       run_q <= run_d;
  end
`else
  assign force_eng = 1'b0;
`endif

  // Round-robin search starting one past the last granted engine.
  always_comb begin
    int unsigned idx;
    rr_found = 1'b0;
    rr_sel   = '0;
    for (int unsigned i = 1; i <= NUM_ENG; i++) begin
      idx = (32'(rr_ptr_q) + i) % NUM_ENG;
      if (!rr_found && eng_req[IDX_W'(idx)]) begin
        rr_found = 1'b1;
        rr_sel   = IDX_W'(idx);
      end
    end
  end

  assign slave_gnt         = ~reset & slave_req & ~force_eng;
  assign eng_gnt_any       = ~reset & rr_found & ~slave_gnt;
  assign eng_gnt           = eng_gnt_any ? (NUM_ENG'(1) << rr_sel) : '0;
  assign slave_waitrequest = slave_req & ~slave_gnt;

  always_comb begin
    ram_address    = '0;
    ram_wren       = 1'b0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    tag0_d         = '0;
    rr_ptr_d       = rr_ptr_q;
    if (slave_gnt) begin
      ram_address     = slave_address;
      ram_wren        = slave_write;
      ram_byteenable  = slave_write ? slave_byteenable : '0;
      ram_writedata   = slave_writedata;
      tag0_d.valid    = slave_read;
      tag0_d.is_slave = 1'b1;
    end else if (eng_gnt_any) begin
      ram_address     = eng_addr[rr_sel*ADDR_WIDTH +: ADDR_WIDTH];
      ram_wren        = eng_we[rr_sel];
      ram_byteenable  = eng_we[rr_sel] ? '1 : '0;
      ram_writedata   = eng_wdata[rr_sel*DATA_WIDTH +: DATA_WIDTH];
      tag0_d.valid    = ~eng_we[rr_sel];
      tag0_d.idx      = rr_sel;
      rr_ptr_d        = rr_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= IDX_W'(NUM_ENG - 1);
      tag0_q   <= '0;
      tag1_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tag0_q   <= tag0_d;
      tag1_q   <= tag0_q;
    end
  end

  // Strobes are gated by reset so a tag already in stage 1 cannot fire during reset.
  assign slave_readdatavalid = ~reset & tag1_q.valid & tag1_q.is_slave;
  assign eng_rvalid          = (~reset & tag1_q.valid & ~tag1_q.is_slave) ?
                               (NUM_ENG'(1) << tag1_q.idx) : '0;
  assign slave_readdata      = ram_readdata;
  assign eng_rdata           = ram_readdata;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Self-checking bench for board_ram_arbiter: arbitration vector table, hand sequences,
// and a read-return scoreboard backed by a reference memory.
module tb_board_ram_arbiter;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NE = 2;

  logic             clk, reset;
  logic [AW-1:0]    slave_address;
  logic             slave_read, slave_write;
  logic [DW-1:0]    slave_writedata;
  logic [3:0]       slave_byteenable;
  logic             slave_waitrequest;
  logic [DW-1:0]    slave_readdata;
  logic             slave_readdatavalid;
  logic [NE-1:0]    eng_req, eng_we, eng_gnt, eng_rvalid;
  logic [NE*AW-1:0] eng_addr;
  logic [NE*DW-1:0] eng_wdata;
  logic [DW-1:0]    eng_rdata;
  logic [AW-1:0]    ram_address;
  logic             ram_wren;
  logic [3:0]       ram_byteenable;
  logic [DW-1:0]    ram_writedata;
  logic [DW-1:0]    ram_readdata;

  logic [AW-1:0]    ea [NE];
  logic [DW-1:0]    ew [NE];
  assign eng_addr  = {ea[1], ea[0]};
  assign eng_wdata = {ew[1], ew[0]};

  board_ram_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENG(NE), .MAX_SLAVE_RUN(4)
  ) dut (
    .clk(clk), .reset(reset),
    .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_byteenable(slave_byteenable),
    .slave_waitrequest(slave_waitrequest), .slave_readdata(slave_readdata),
    .slave_readdatavalid(slave_readdatavalid),
    .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered address and registered output (2-cycle read latency).
  logic [DW-1:0] mem [256];
  logic [AW-1:0] raddr_q;
  logic [DW-1:0] rdata_q;
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
    end else if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
    end
    raddr_q <= ram_address;
    rdata_q <= mem[raddr_q];
  end
  assign ram_readdata = rdata_q;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic        is_slave;
    int unsigned idx;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];
  logic [DW-1:0] ref_mem [256];

  // Scoreboard: pushes on accepted reads, pops and compares on the return cycle.
  initial begin : mon
    exp_t e;
    logic [2:0] strobe, exp_strobe;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA000_0000 + i;
    forever begin
      @(negedge clk);
      strobe = {eng_rvalid, slave_readdatavalid};
      if (reset) begin
        sb.delete();
        check("rst_rvalid", 32'(strobe), 32'd0);
      end else begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
          e = sb.pop_front();
          exp_strobe = e.is_slave ? 3'b001 : (3'b010 << e.idx);
          check("rd_route", 32'(strobe), 32'(exp_strobe));
          check("rd_data", e.is_slave ? slave_readdata : eng_rdata, e.data);
        end else begin
          check("rd_idle", 32'(strobe), 32'd0);
        end
        if (slave_read && !slave_waitrequest) begin
          e.is_slave = 1'b1; e.idx = 0; e.data = ref_mem[slave_address]; e.due = cyc + 2;
          sb.push_back(e);
        end
        if (slave_write && !slave_waitrequest)
          for (int b = 0; b < 4; b++)
            if (slave_byteenable[b]) ref_mem[slave_address][8*b +: 8] = slave_writedata[8*b +: 8];
        for (int i = 0; i < NE; i++) begin
          if (eng_req[i] && eng_gnt[i]) begin
            if (eng_we[i]) ref_mem[ea[i]] = ew[i];
            else begin
              e.is_slave = 1'b0; e.idx = i; e.data = ref_mem[ea[i]]; e.due = cyc + 2;
              sb.push_back(e);
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       srd, swr;
    logic [1:0] ereq, ewe;
    logic       exp_wait;
    logic [1:0] exp_gnt;
    logic       exp_wren;
    logic [3:0] exp_be;
  } vec_t;
  vec_t tbl[10];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input logic srd, input logic swr, input logic [AW-1:0] sa,
                        input logic [31:0] sd, input logic [3:0] sbe,
                        input logic [1:0] req, input logic [1:0] we);
    slave_read = srd; slave_write = swr; slave_address = sa;
    slave_writedata = sd; slave_byteenable = sbe; eng_req = req; eng_we = we;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, '0, '0, '0, 2'b00, 2'b00);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    set_in(0, 0, '0, '0, '0, 2'b00, 2'b00);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    int fc;
    logic       ew_exp;
    logic [1:0] eg_exp;
    //           srd swr ereq   ewe    wait gnt    wren be
    tbl[0] = '{1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 4'h0};
    tbl[1] = '{1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 2'b01, 1'b0, 4'h0};
    tbl[2] = '{1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 4'h0};
    tbl[3] = '{1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 2'b10, 1'b0, 4'h0};
    tbl[4] = '{1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 4'hF};
    tbl[5] = '{1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 2'b00, 1'b1, 4'h2};
    tbl[6] = '{1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 4'h0};
    tbl[7] = '{1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 4'h0};
    tbl[8] = '{1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 4'h0};
    tbl[9] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 4'h0};

    ea[0] = 8'd1; ea[1] = 8'd2; ew[0] = '0; ew[1] = 32'hCAFE_0002;
    reset = 1'b1;
    set_in(1, 0, 8'd5, '0, '0, 2'b11, 2'b00);
    @(negedge clk);
    check("rst_wait", 32'(slave_waitrequest), 32'd1);
    check("rst_gnt", 32'(eng_gnt), 32'd0);
    check("rst_wren", 32'(ram_wren), 32'd0);
    tick(); tick();
    reset = 1'b0;
    idle(1);

    do_reset();
    for (int v = 0; v < 10; v++) begin
      set_in(tbl[v].srd, tbl[v].swr, 8'd5, 32'h1234_5678, 4'h2, tbl[v].ereq, tbl[v].ewe);
      @(negedge clk);
      check($sformatf("tbl%0d_wait", v), 32'(slave_waitrequest), 32'(tbl[v].exp_wait));
      check($sformatf("tbl%0d_gnt", v), 32'(eng_gnt), 32'(tbl[v].exp_gnt));
      check($sformatf("tbl%0d_wren", v), 32'(ram_wren), 32'(tbl[v].exp_wren));
      check($sformatf("tbl%0d_be", v), 32'(ram_byteenable), 32'(tbl[v].exp_be));
      tick();
    end
    idle(3);

    // Slave write then read back.
    set_in(0, 1, 8'd5, 32'h0000_00AB, 4'hF, 2'b00, 2'b00);
    @(negedge clk); check("A_wr_wait", 32'(slave_waitrequest), 32'd0); tick();
    set_in(1, 0, 8'd5, '0, '0, 2'b00, 2'b00);
    @(negedge clk); check("A_rd_wait", 32'(slave_waitrequest), 32'd0); tick();
    idle(3);

    // Both engines continuously reading from reset: strict alternation.
    do_reset();
    set_in(0, 0, '0, '0, '0, 2'b11, 2'b00);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("B_gnt%0d", k), 32'(eng_gnt), (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end
    idle(3);

    // Slave write and eng0 read of same address collide; engine sees new value.
    ea[0] = 8'd7;
    set_in(0, 1, 8'd7, 32'h7777_0007, 4'hF, 2'b01, 2'b00);
    @(negedge clk);
    check("C_slv_wait", 32'(slave_waitrequest), 32'd0);
    check("C_gnt0", 32'(eng_gnt), 32'd0);
    tick();
    set_in(0, 0, '0, '0, '0, 2'b01, 2'b00);
    @(negedge clk); check("C_gnt1", 32'(eng_gnt), 32'd1); tick();
    idle(3);
    ea[0] = 8'd1;

    // Continuous slave reads with eng1 waiting.
    set_in(1, 0, 8'd5, '0, '0, 2'b10, 2'b00);
    fc = 0;
    for (int k = 0; k < 12; k++) begin
`ifdef ARB_FAIR_EN
      if (fc == 4) begin ew_exp = 1'b1; eg_exp = 2'b10; fc = 0; end
      else begin ew_exp = 1'b0; eg_exp = 2'b00; fc++; end
`else
      ew_exp = 1'b0; eg_exp = 2'b00;
`endif
      @(negedge clk);
      check($sformatf("D_wait%0d", k), 32'(slave_waitrequest), 32'(ew_exp));
      check($sformatf("D_gnt%0d", k), 32'(eng_gnt), 32'(eg_exp));
      tick();
    end
    idle(3);

    // Engine full-word write, then slave byte-lane write, then read back.
    ea[0] = 8'd9; ew[0] = 32'h0BAD_F00D;
    set_in(0, 0, '0, '0, '0, 2'b01, 2'b01);
    @(negedge clk);
    check("E_eng_gnt", 32'(eng_gnt), 32'd1);
    check("E_eng_wren", 32'(ram_wren), 32'd1);
    check("E_eng_be", 32'(ram_byteenable), 32'hF);
    tick();
    set_in(0, 1, 8'd9, 32'h1122_3344, 4'h2, 2'b00, 2'b00);
    @(negedge clk);
    check("E_slv_be", 32'(ram_byteenable), 32'h2);
    check("E_slv_wdata", ram_writedata, 32'h1122_3344);
    tick();
    set_in(1, 0, 8'd9, '0, '0, 2'b00, 2'b00);
    @(negedge clk); check("E_rd_wait", 32'(slave_waitrequest), 32'd0); tick();
    idle(3);
    ea[0] = 8'd1;

    // Reset one cycle after an eng0 read grant: read discarded, eng0 served first after.
    do_reset();
    set_in(0, 0, '0, '0, '0, 2'b01, 2'b00);
    @(negedge clk); check("F_gnt_pre", 32'(eng_gnt), 32'd1); tick();
    reset = 1'b1;
    set_in(1, 0, 8'd5, '0, '0, 2'b11, 2'b00);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("F_rst_gnt", 32'(eng_gnt), 32'd0);
      check("F_rst_wren", 32'(ram_wren), 32'd0);
      check("F_rst_wait", 32'(slave_waitrequest), 32'd1);
      tick();
    end
    reset = 1'b0;
    set_in(0, 0, '0, '0, '0, 2'b11, 2'b00);
    @(negedge clk); check("F_first_gnt", 32'(eng_gnt), 32'd1); tick();
    idle(4);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
